// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types and helpers shared by the two-master memory arbiter.
//   arb_state_e     - arbiter FSM states
//   master_idx_t    - index of a requesting master (one bit for two masters)
//   ARB_NUM_MASTERS - number of masters sharing the slave port
//   arb_pick        - winner selection given both valids and the favoured master
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef logic master_idx_t;

  localparam int ARB_NUM_MASTERS = 2;

  // On a tie the favoured master wins; otherwise whichever master is asking.
  function automatic master_idx_t arb_pick(input logic v0, input logic v1,
                                           input master_idx_t favoured);
    master_idx_t w;
    if (v0 && v1) begin
      w = favoured;
    end else if (v0) begin
      w = 1'b0;
    end else begin
      w = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: per-transaction response watchdog.
//   clk_i      clock
//   reset_i    synchronous active-high reset
//   clr_i      restart the count at zero (issued when a grant is made)
//   en_i       advance the count by one this cycle
//   expired_o  count has reached TIMEOUT
// The count is cleared on every grant and only advances while the arbiter
// stays in its busy state, so it never passes TIMEOUT and never wraps.
module mem_arb_wdog #(
  parameter int TIMEOUT = 255,
  localparam int W      = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: shares one valid/ready native memory port between two masters.
// One transaction at a time is forwarded to the slave; the response goes back
// to the granted master as a one-cycle ready pulse. A watchdog terminates a
// transaction the slave never answers, returning ERR_RDATA and pulsing
// timeout_err.
//   clk, reset                     clock, synchronous active-high reset
//   mX_valid/instr/addr/wdata/wstrb  master requests (wstrb == 0 is a read)
//   mX_ready, mX_rdata             per-master completion pulse and data
//   s_valid/instr/addr/wdata/wstrb registered copy of the granted request
//   s_ready, s_rdata               slave completion and read data
//   grant_id                       master most recently granted
//   timeout_err                    pulse when the watchdog ended a transaction
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; without it
// m0 always wins a simultaneous request.
module mem_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant_id,
  output logic        timeout_err
);

  arb_state_e  state_q, state_d;
  logic        s_valid_q, s_valid_d;
  logic        s_instr_q, s_instr_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  master_idx_t grant_q, grant_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        timeout_err_q, timeout_err_d;

  master_idx_t prio_s;
  master_idx_t win_s;
  logic        wd_clr_s;
  logic        wd_en_s;
  logic        wd_expired_s;
  logic [31:0] resp_data_s;

`ifdef MEM_ARB_RR_EN
  master_idx_t prio_q, prio_d;

  // After each completed transaction the other master gets the tie-break.
  always_comb begin
    prio_d = prio_q;
    if (state_q == ARB_RESP) begin
      prio_d = ~grant_q;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio_s = prio_q;
`else
  assign prio_s = 1'b0;
`endif

  assign win_s = arb_pick(m0_valid, m1_valid, prio_s);

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (wd_clr_s),
    .en_i      (wd_en_s),
    .expired_o (wd_expired_s)
  );

  // FSM next state and next values of all registered outputs.
  always_comb begin
    state_d       = state_q;
    s_valid_d     = s_valid_q;
    s_instr_d     = s_instr_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    s_wstrb_d     = s_wstrb_q;
    grant_d       = grant_q;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    timeout_err_d = 1'b0;
    wd_clr_s      = 1'b0;
    wd_en_s       = 1'b0;
    resp_data_s   = s_rdata;

    case (state_q)
      ARB_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d   = ARB_BUSY;
          grant_d   = win_s;
          s_valid_d = 1'b1;
          wd_clr_s  = 1'b1;
          if (win_s == 1'b1) begin
            s_instr_d = m1_instr;
            s_addr_d  = m1_addr;
            s_wdata_d = m1_wdata;
            s_wstrb_d = m1_wstrb;
          end else begin
            s_instr_d = m0_instr;
            s_addr_d  = m0_addr;
            s_wdata_d = m0_wdata;
            s_wstrb_d = m0_wstrb;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end

      ARB_BUSY: begin
        // A slave answer in the expiry cycle takes precedence over the timeout.
        if (s_ready || wd_expired_s) begin
          state_d   = ARB_RESP;
          s_valid_d = 1'b0;
          if (s_ready) begin
            resp_data_s = s_rdata;
          end else begin
            resp_data_s   = ERR_RDATA;
            timeout_err_d = 1'b1;
          end
          if (grant_q == 1'b1) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = resp_data_s;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = resp_data_s;
          end
        end else begin
          state_d = ARB_BUSY;
          wd_en_s = 1'b1;
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d   = ARB_IDLE;
        s_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      s_valid_q     <= 1'b0;
      s_instr_q     <= 1'b0;
      s_addr_q      <= 32'h0;
      s_wdata_q     <= 32'h0;
      s_wstrb_q     <= 4'h0;
      grant_q       <= 1'b0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      m0_rdata_q    <= 32'h0;
      m1_rdata_q    <= 32'h0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_valid_q     <= s_valid_d;
      s_instr_q     <= s_instr_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      s_wstrb_q     <= s_wstrb_d;
      grant_q       <= grant_d;
      m0_ready_q    <= m0_ready_d;
      m1_ready_q    <= m1_ready_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign s_valid     = s_valid_q;
  assign s_instr     = s_instr_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;
  assign grant_id    = grant_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: directed plus randomized bench for mem_arbiter2 (TIMEOUT=8).
// A behavioural slave with a sparse memory answers after a chosen latency
// (0 = never). Expected grant order, latency, data and timeouts come from a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter2;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m0_instr = 1'b0;
  logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
  logic [3:0]  m0_wstrb = 4'h0;
  logic        m0_ready;
  logic [31:0] m0_rdata;
  logic        m1_valid = 1'b0, m1_instr = 1'b0;
  logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
  logic [3:0]  m1_wstrb = 4'h0;
  logic        m1_ready;
  logic [31:0] m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = 32'h0;
  logic        grant_id, timeout_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  bit          last_win = 1'b1;   // model: m0 is favoured out of reset
  int          gq[$];
  logic [31:0] last_rdata0, last_rdata1;
  int          last_ready_cyc;

  mem_arbiter2 #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] r;
    if (mem.exists(a)) r = mem[a];
    else r = {a[15:0], 16'h5A5A};
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Arbitration rule: single requester wins; ties go by configuration.
  function automatic int pick(input bit p0, input bit p1);
    if (p0 && p1) begin
`ifdef MEM_ARB_RR_EN
      return (last_win == 1'b0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return p0 ? 0 : 1;
  endfunction

  task automatic set_m0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                        input logic ins);
    m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = st; m0_instr = ins;
  endtask

  task automatic set_m1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                        input logic ins);
    m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = st; m1_instr = ins;
  endtask

  // Serve all pending requests; called right after a negedge with the DUT idle.
  // mX_rep: extra back-to-back reads a master issues after each completion.
  task automatic run_round(input int lat, input int m0_rep, input int m1_rep);
    int cyc = 0, rel = 0, exp_rel = 0, next_grant = 1, busy_n = 0;
    int err_n = 0, exp_err = 0, win = 0;
    int r0 = m0_rep, r1 = m1_rep;
    bit done0 = !m0_valid, done1 = !m1_valid, in_txn = 1'b0, timed = 1'b0, is_wr = 1'b0;
    logic [31:0] exp_d = 32'h0;
    while (!(done0 && done1) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!in_txn && cyc == next_grant) begin
        win     = pick(!done0, !done1);
        in_txn  = 1'b1;
        rel     = 0;
        timed   = !(lat >= 1 && lat <= TO);
        exp_rel = timed ? TO + 2 : lat + 2;
        is_wr   = (win == 1) ? (m1_wstrb != 4'h0) : (m0_wstrb != 4'h0);
        exp_d   = timed ? ERR : mem_rd((win == 1) ? m1_addr : m0_addr);
        if (timed) exp_err++;
        gq.push_back(win);
      end
      if (in_txn) rel++;
      if (in_txn && rel == 1) begin
        chk("grant_id", grant_id, win);
        chk("s_addr",  s_addr,  (win == 1) ? m1_addr  : m0_addr);
        chk("s_wdata", s_wdata, (win == 1) ? m1_wdata : m0_wdata);
        chk("s_wstrb", s_wstrb, (win == 1) ? m1_wstrb : m0_wstrb);
        chk("s_instr", s_instr, (win == 1) ? m1_instr : m0_instr);
      end
      chk("s_valid",  s_valid,  in_txn && rel < exp_rel);
      chk("m0_ready", m0_ready, in_txn && rel == exp_rel && win == 0);
      chk("m1_ready", m1_ready, in_txn && rel == exp_rel && win == 1);
      if (timeout_err === 1'b1) err_n++;
      if (in_txn && rel == exp_rel) begin
        last_ready_cyc = cyc;
        last_win = (win == 1);
        if (win == 0) begin
          if (!is_wr) chk("m0_rdata", m0_rdata, exp_d);
          last_rdata0 = m0_rdata;
          if (r0 > 0) begin
            r0--; m0_addr = 32'h300 + 32'($urandom_range(0, 7)) * 32'd4; m0_wstrb = 4'h0;
          end else begin
            m0_valid = 1'b0; done0 = 1'b1;
          end
        end else begin
          if (!is_wr) chk("m1_rdata", m1_rdata, exp_d);
          last_rdata1 = m1_rdata;
          if (r1 > 0) begin
            r1--; m1_addr = 32'h380 + 32'($urandom_range(0, 7)) * 32'd4; m1_wstrb = 4'h0;
          end else begin
            m1_valid = 1'b0; done1 = 1'b1;
          end
        end
        in_txn = 1'b0;
        next_grant = cyc + 2;
      end
      // behavioural slave
      if (s_valid === 1'b1) busy_n++; else busy_n = 0;
      s_ready = (lat > 0 && busy_n == lat + 1);
      if (s_ready) begin
        s_rdata = mem_rd(s_addr);
        if (s_wstrb != 4'h0) mem[s_addr] = merge(mem_rd(s_addr), s_wdata, s_wstrb);
      end else begin
        s_rdata = $urandom();
      end
    end
    chk("round_done", {30'h0, done1, done0}, 32'h3);
    chk("tmo_pulses", err_n, exp_err);
    @(negedge clk);
    chk("idle_s_valid", s_valid, 1'b0);
    chk("idle_tmo", timeout_err, 1'b0);
  endtask

  initial begin
    int lats[7] = '{0, 1, 2, 3, 5, 8, 9};
    mem[32'h100] = 32'h000000FF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // reset values
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_m0_ready", m0_ready, 1'b0);
    chk("rst_m1_ready", m1_ready, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);

    // simultaneous requests, each master issuing four reads
    gq.delete();
    set_m0(32'h300, 32'h0, 4'h0, 1'b0);
    set_m1(32'h380, 32'h0, 4'h0, 1'b1);
    run_round(1, 3, 3);
`ifdef MEM_ARB_RR_EN
    chk("arb_g0", gq[0], 0); chk("arb_g1", gq[1], 1);
    chk("arb_g2", gq[2], 0); chk("arb_g3", gq[3], 1);
`else
    chk("arb_g0", gq[0], 0); chk("arb_g1", gq[1], 0);
    chk("arb_g2", gq[2], 0); chk("arb_g3", gq[3], 0);
    chk("arb_g4", gq[4], 1);
`endif

    // single read with a one-cycle slave
    set_m0(32'h100, 32'h0, 4'h0, 1'b0);
    run_round(1, 0, 0);
    chk("single_rdata", last_rdata0, 32'h000000FF);
    chk("single_lat", last_ready_cyc, 3);

    // write pass-through then read back
    set_m1(32'h104, 32'h5, 4'hF, 1'b1);
    run_round(1, 0, 0);
    set_m1(32'h104, 32'h0, 4'h0, 1'b0);
    run_round(2, 0, 0);
    chk("wr_readback", last_rdata1, 32'h5);

    // silent slave: watchdog ends the access, then normal service
    set_m0(32'h120, 32'h0, 4'h0, 1'b0);
    run_round(0, 0, 0);
    chk("tmo_rdata", last_rdata0, ERR);
    chk("tmo_lat", last_ready_cyc, TO + 2);
    set_m0(32'h100, 32'h0, 4'h0, 1'b0);
    run_round(1, 0, 0);
    chk("post_tmo_rdata", last_rdata0, 32'h000000FF);

    // slave answers in the expiry cycle
    set_m1(32'h100, 32'h0, 4'h0, 1'b0);
    run_round(TO, 0, 0);
    chk("race_rdata", last_rdata1, 32'h000000FF);

    // reset while busy abandons the access; held request is served afterwards
    set_m0(32'h100, 32'h0, 4'h0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("pre_rst_m0_ready", m0_ready, 1'b0);
    end
    chk("pre_rst_busy", s_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_win = 1'b1;
    chk("mid_rst_s_valid", s_valid, 1'b0);
    chk("mid_rst_m0_ready", m0_ready, 1'b0);
    chk("mid_rst_m1_ready", m1_ready, 1'b0);
    chk("mid_rst_m0_rdata", m0_rdata, 32'h0);
    chk("mid_rst_s_addr", s_addr, 32'h0);
    chk("mid_rst_grant", grant_id, 1'b0);
    gq.delete();
    run_round(1, 0, 0);
    chk("regrant_m0", gq[0], 0);
    chk("regrant_rdata", last_rdata0, 32'h000000FF);

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      int pat = $urandom_range(1, 3);
      int li  = $urandom_range(0, 6);
      if (pat[0]) set_m0(32'h200 + 32'($urandom_range(0, 7)) * 32'd4, $urandom(),
                         ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                         1'($urandom_range(0, 1)));
      if (pat[1]) set_m1(32'h200 + 32'($urandom_range(0, 7)) * 32'd4, $urandom(),
                         ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                         1'($urandom_range(0, 1)));
      run_round(lats[li], 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-master arbiter sharing one native-interface memory port (valid/ready/addr/wdata/wstrb/rdata, picorv32 style) between requesters, e.g. the CPU core and a DMA/loader engine. It serializes transactions, forwards one request at a time to the memory slave, and returns the response to the granted master. A per-transaction watchdog completes stalled accesses with an error word so that neither master hangs.

## Interface
- TIMEOUT, 255: slave-response cycle limit per transaction; legal range is ≥1.
- ERR_RDATA, 32'hDEADBEEF: read data returned to the master on timeout.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_valid / m1_valid  in  1  request; held stable until the matching ready.
- m0_instr / m1_instr  in  1  instruction-fetch flag; forwarded to the slave.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 means read.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  response data; valid while the matching ready is high.
- s_valid  out  1  request to the slave.
- s_instr, s_addr[31:0], s_wdata[31:0], s_wstrb[3:0]  out  registered copy of the granted request.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data; sampled when s_ready is high.
- grant_id  out  1  index of the master that was last granted.
- timeout_err  out  1  one-cycle pulse when a transaction is terminated by the watchdog.

## Operation
- FSM states are ARB_IDLE, ARB_BUSY and ARB_RESP.
- ARB_IDLE
  - If any mX_valid is high: select a winner, register its request onto s_*, set grant_id, clear the watchdog, and go to ARB_BUSY.
  - With no valid request, stay in ARB_IDLE.
- ARB_BUSY
  - s_valid is 1 and the watchdog increments each cycle.
  - If s_ready is high: capture s_rdata and go to ARB_RESP.
  - Else, if the watchdog equals TIMEOUT: load ERR_RDATA, pulse timeout_err, and go to ARB_RESP.
  - If s_ready and the timeout occur in the same cycle, s_ready wins and no error is flagged.
- ARB_RESP
  - s_valid is 0.
  - m[grant_id]_ready = 1 for exactly one cycle, with the captured data on m[grant_id]_rdata.
  - Update the priority pointer, then go to ARB_IDLE.
- The ungranted master's ready stays 0 and its request waits, unobserved, until the next ARB_IDLE.
- s_ready is ignored outside ARB_BUSY. A late response after a timeout is discarded.
- Writes follow the same flow. The rdata returned for a write is the captured s_rdata, and its content carries no meaning.
- Watchdog width is $clog2(TIMEOUT+1). It never wraps, because it is cleared on entry to ARB_BUSY.

## Timing
- Reset values of all outputs are 0: mX_ready, mX_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb, grant_id and timeout_err.
- Reset also sets the FSM to ARB_IDLE, clears the watchdog, and sets the priority pointer to m0.
- Reset mid-transaction abandons the transaction. No ready is issued to either master.
- Cycle sequence for a request sampled in ARB_IDLE at cycle 0:
  - s_valid rises at cycle 1.
  - s_ready is first sampled at cycle 1.
  - With a 1-cycle slave, s_ready is seen at cycle 2 and mX_ready is high at cycle 3.
  - Latency is slave latency + 2 cycles.
- Minimum spacing between back-to-back grants is 4 cycles for a 1-cycle slave: IDLE, BUSY, BUSY, RESP.
- With a silent slave, timeout_err and the transition to ARB_RESP occur on the cycle in which the count reaches TIMEOUT. mX_ready then follows one cycle later.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. On a simultaneous request, the master not granted last wins. The pointer updates in ARB_RESP, including after a timeout.
- MEM_ARB_RR_EN undefined: fixed priority. m0 always wins a simultaneous request, and m1 can starve. The pointer register is absent and grant_id still reports the winner.

## Structure
- The shared package mem_arb_pkg holds:
  - typedef arb_state_e (ARB_IDLE, ARB_BUSY, ARB_RESP)
  - typedef master_idx_t (1 bit)
  - localparam ARB_NUM_MASTERS = 2
- Sub-module mem_arb_wdog implements the watchdog: the TIMEOUT counter with clear and enable, and an expiry flag.

## Test plan
- Single read: m0 reads 0x100, and the 1-cycle slave returns 0x000000FF. Required: m0_ready pulses once, at cycle 3, with m0_rdata = 0xFF, and m1_ready stays 0.
- Write pass-through: m1 writes 0x5 to 0x104 with wstrb = 4'hF. Required: the slave sees s_addr = 0x104, s_wdata = 5, s_wstrb = F and s_instr = m1_instr. A following read returns 5.
- Simultaneous requests, repeated 4 times with MEM_ARB_RR_EN: grants alternate 0,1,0,1. Without the macro, all grants go to m0 until m0 drops its request.
- Timeout with TIMEOUT = 8 and a slave that never asserts ready: timeout_err pulses once, and m0_rdata = 0xDEADBEEF with m0_ready. The next request is served normally.
- s_ready arriving on the same cycle as the timeout: the slave data is returned and timeout_err stays 0.
- reset asserted for 1 cycle while in ARB_BUSY: all outputs are 0 on the next cycle, no mX_ready is issued, and the held request is re-granted to m0.
